// File: rtl/accel_spi_responder_if.sv
// SPI pin bundle between a mode-3 SPI master and the accelerometer responder.
// Framing: spi_csn low brackets a frame; MOSI is valid at SCLK rise, MISO changes after SCLK fall
// and is meaningful only while miso_oe is 1 (the pin floats otherwise).
interface accel_spi_responder_if;
  logic spi_csn;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic miso_oe;

  modport master (
    output spi_csn,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso,
    input  miso_oe
  );

  modport slave (
    input  spi_csn,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso,
    output miso_oe
  );
endinterface

// File: rtl/accel_spi_responder.sv
// Oversampled SPI (mode 3) target modelling a 3-axis accelerometer: command decode,
// small register file and an incrementing X/Y/Z sample pattern.
module accel_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
  parameter logic [7:0] X_INIT       = 8'h9A,
  parameter logic [7:0] X_STEP       = 8'h20
) (
  input  logic                        clk_in,
  input  logic                        nrst,
  accel_spi_responder_if.slave        spi,
  output logic [7:0]                  ctrl_reg1,
  output logic [7:0]                  temp_cfg,
  output logic [7:0]                  ctrl_reg4,
  output logic                        frame_done,
  output logic [1:0]                  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // [0],[1] form the synchronizer, [2] is the previous value for edge detection.
  // CSN resets to 0 so a bus held low across reset never looks like a fresh csn_fall.
  logic [2:0] csn_sr;
  logic [2:0] sclk_sr;
  logic [1:0] mosi_sr;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      csn_sr  <= 3'b000;
      sclk_sr <= 3'b111;
      mosi_sr <= 2'b00;
    end else begin
      csn_sr  <= {csn_sr[1:0], spi.spi_csn};
      sclk_sr <= {sclk_sr[1:0], spi.spi_sclk};
      mosi_sr <= {mosi_sr[0], spi.spi_mosi};
    end
  end

  logic csn_fall, csn_rise, sclk_rise, sclk_fall, mosi_s;
  assign csn_fall  = ~csn_sr[1] &  csn_sr[2];
  assign csn_rise  =  csn_sr[1] & ~csn_sr[2];
  assign sclk_rise =  sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] &  sclk_sr[2];
  assign mosi_s    = mosi_sr[1];

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] shift_out;
  logic       rw;
  logic       ms;
  logic [5:0] addr;
  logic [7:0] x_l;
  logic       x_read;
  logic [5:0] next_addr;
  logic [5:0] cmd_addr;
  logic [7:0] wdata;

  assign next_addr = ms ? addr + 6'd1 : addr;
  assign cmd_addr  = {shift_in[4:0], mosi_s};
  assign wdata     = {shift_in[6:0], mosi_s};
  assign state_dbg = state;

  function automatic logic [7:0] read_reg(input logic [5:0] a);
    case (a)
      6'h0F:   return WHO_AM_I_VAL;
      6'h1F:   return temp_cfg;
      6'h20:   return ctrl_reg1;
      6'h23:   return ctrl_reg4;
      6'h28:   return x_l;
      6'h2A:   return x_l + 8'd1;
      6'h2C:   return x_l + 8'd2;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      bit_cnt      <= 3'd0;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      rw           <= 1'b0;
      ms           <= 1'b0;
      addr         <= 6'h00;
      x_l          <= X_INIT;
      x_read       <= 1'b0;
      spi.spi_miso <= 1'b0;
      spi.miso_oe  <= 1'b0;
      frame_done   <= 1'b0;
      ctrl_reg1    <= 8'h07;
      temp_cfg     <= 8'h00;
      ctrl_reg4    <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (csn_rise) begin
        // Partial bytes are simply dropped: nothing below commits until bit 8.
        if (state != S_IDLE) begin
          frame_done <= 1'b1;
          if (x_read) x_l <= x_l + X_STEP;
        end
        state       <= S_IDLE;
        bit_cnt     <= 3'd0;
        x_read      <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else if (csn_fall) begin
        state       <= S_CMD;
        bit_cnt     <= 3'd0;
        x_read      <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else begin
        case (state)
          S_CMD: begin
            if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= wdata;
              if (bit_cnt == 3'd7) begin
                rw    <= shift_in[6];
                ms    <= shift_in[5];
                addr  <= cmd_addr;
                state <= S_DATA;
                if (shift_in[6]) shift_out <= read_reg(cmd_addr);
              end
            end
          end
          S_DATA: begin
            if (rw) begin
              if (sclk_fall) begin
                spi.miso_oe  <= 1'b1;
                spi.spi_miso <= shift_out[7];
                bit_cnt      <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (addr == 6'h28) x_read <= 1'b1;
                  addr      <= next_addr;
                  shift_out <= read_reg(next_addr);
                end else begin
                  shift_out <= {shift_out[6:0], 1'b0};
                end
              end
            end else if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= wdata;
              if (bit_cnt == 3'd7) begin
                case (addr)
                  6'h1F:   temp_cfg  <= wdata;
                  6'h20:   ctrl_reg1 <= wdata;
                  6'h23:   ctrl_reg4 <= wdata;
                  default: ;
                endcase
                addr <= next_addr;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: a mode-3 master drives frames, received bytes
// are matched against a scoreboard queue by a separate monitor process.
module tb_accel_spi_responder;

  localparam int HALF = 8;

  logic       clk_in;
  logic       nrst;
  logic [7:0] ctrl_reg1, temp_cfg, ctrl_reg4;
  logic       frame_done;
  logic [1:0] state_dbg;

  accel_spi_responder_if spi_bus ();

  accel_spi_responder dut (
    .clk_in     (clk_in),
    .nrst       (nrst),
    .spi        (spi_bus.slave),
    .ctrl_reg1  (ctrl_reg1),
    .temp_cfg   (temp_cfg),
    .ctrl_reg4  (ctrl_reg4),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_buf [0:7];

  always @(posedge clk_in) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk_in);
      while (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          check("rx_unexpected", got, 8'hxx);
        end else begin
          check("rx_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    repeat (4) @(negedge clk_in);
    nrst = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  // One frame of nbits from tx_buf; rst_bit >= 0 pulses nrst before that bit.
  task automatic spi_frame(input int nbits, input int rst_bit, input int exp_fd, input bit score_rx);
    int   fd0;
    bit   oe_bad;
    bit   after_rst;
    bit   is_read;
    logic [7:0] rx;
    logic miso_bit;
    fd0 = fd_cnt;
    oe_bad = 1'b0;
    after_rst = 1'b0;
    is_read = tx_buf[0][7];
    rx = 8'h00;
    spi_bus.spi_csn = 1'b0;
    repeat (HALF) @(negedge clk_in);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        nrst = 1'b0;
        repeat (3) @(negedge clk_in);
        nrst = 1'b1;
        after_rst = 1'b1;
      end
      spi_bus.spi_sclk = 1'b0;
      spi_bus.spi_mosi = tx_buf[b / 8][7 - (b % 8)];
      repeat (HALF) @(negedge clk_in);
      if (!after_rst && (spi_bus.miso_oe !== (is_read && b >= 8))) oe_bad = 1'b1;
      miso_bit = spi_bus.miso_oe ? spi_bus.spi_miso : 1'b1;
      spi_bus.spi_sclk = 1'b1;
      rx = {rx[6:0], miso_bit};
      if ((b % 8) == 7 && b >= 8 && score_rx) rx_q.push_back(rx);
      repeat (HALF) @(negedge clk_in);
    end
    spi_bus.spi_csn = 1'b1;
    repeat (12) @(negedge clk_in);
    check("frame_done_count", 8'(fd_cnt - fd0), 8'(exp_fd));
    check("miso_oe_window", {7'd0, oe_bad}, 8'h00);
    check("miso_oe_idle", {7'd0, spi_bus.miso_oe}, 8'h00);
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                        input logic [7:0] b6);
    tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3;
    tx_buf[4] = b4; tx_buf[5] = b5; tx_buf[6] = b6; tx_buf[7] = 8'h00;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    set_tx(a, d, 0, 0, 0, 0, 0);
    exp_q.push_back(8'hFF);
    spi_frame(16, -1, 1, 1'b1);
  endtask

  // Main sequence: driver calls with expected bytes pushed up front
  initial begin
    spi_bus.spi_csn  = 1'b1;
    spi_bus.spi_sclk = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    nrst = 1'b0;
    repeat (5) @(negedge clk_in);
    check("rst_ctrl_reg1", ctrl_reg1, 8'h07);
    check("rst_temp_cfg", temp_cfg, 8'h00);
    check("rst_ctrl_reg4", ctrl_reg4, 8'h00);
    check("rst_miso", {7'd0, spi_bus.spi_miso}, 8'h00);
    check("rst_miso_oe", {7'd0, spi_bus.miso_oe}, 8'h00);
    check("rst_frame_done", {7'd0, frame_done}, 8'h00);
    check("rst_state", {6'd0, state_dbg}, 8'h00);
    nrst = 1'b1;
    repeat (5) @(negedge clk_in);

    // WHO_AM_I
    set_tx(8'h8F, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h33);
    spi_frame(16, -1, 1, 1'b1);

    // Register writes
    write_reg(8'h20, 8'h77);
    check("wr_ctrl_reg1", ctrl_reg1, 8'h77);
    write_reg(8'h1F, 8'hC0);
    check("wr_temp_cfg", temp_cfg, 8'hC0);
    write_reg(8'h23, 8'h88);
    check("wr_ctrl_reg4", ctrl_reg4, 8'h88);
    write_reg(8'h0F, 8'h12);
    check("ro_write_ignored", ctrl_reg1, 8'h77);

    // Readback of a RW register
    set_tx(8'hA0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h77);
    spi_frame(16, -1, 1, 1'b1);

    // Sample counter steps once per frame that read OUT_X_L
    for (int i = 0; i < 3; i++) begin
      set_tx(8'hE8, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(8'h9A + 8'(i * 32));
      exp_q.push_back(8'h00);
      spi_frame(24, -1, 1, 1'b1);
    end

    do_reset();
    check("rst2_ctrl_reg1", ctrl_reg1, 8'h07);

    set_tx(8'hE8, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h9A); exp_q.push_back(8'h00);
    exp_q.push_back(8'h9B); exp_q.push_back(8'h00);
    exp_q.push_back(8'h9C); exp_q.push_back(8'h00);
    spi_frame(56, -1, 1, 1'b1);

    set_tx(8'hA8, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'hBA); exp_q.push_back(8'hBA);
    spi_frame(24, -1, 1, 1'b1);

    // Aborted write after 4 data bits
    set_tx(8'h20, 8'hAA, 0, 0, 0, 0, 0);
    spi_frame(12, -1, 1, 1'b0);
    check("abort_ctrl_reg1", ctrl_reg1, 8'h07);

    // Auto-increment write burst 0x20..0x23
    set_tx(8'h60, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0);
    repeat (4) exp_q.push_back(8'hFF);
    spi_frame(40, -1, 1, 1'b1);
    check("burst_ctrl_reg1", ctrl_reg1, 8'h11);
    check("burst_ctrl_reg4", ctrl_reg4, 8'h44);

    // Reset in the middle of a read frame
    set_tx(8'h8F, 0, 0, 0, 0, 0, 0);
    spi_frame(16, 12, 0, 1'b0);
    check("midrst_ctrl_reg1", ctrl_reg1, 8'h07);
    check("midrst_ctrl_reg4", ctrl_reg4, 8'h00);
    check("midrst_temp_cfg", temp_cfg, 8'h00);

    set_tx(8'h8F, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h33);
    spi_frame(16, -1, 1, 1'b1);

    set_tx(8'hE8, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h9A); exp_q.push_back(8'h00);
    spi_frame(24, -1, 1, 1'b1);

    repeat (20) @(negedge clk_in);
    check("exp_q_drained", 8'(exp_q.size()), 8'h00);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
